// File: rtl/gf2m_reduce_131.sv
// rtl/gf2m_reduce_131.sv - Sequential GF(2^131) reducer, folds FOLD product bits per cycle modulo x^131+x^8+x^3+x^2+1.
module gf2m_reduce_131 #(
    parameter int FOLD = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [260:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [130:0] out_data
);

    localparam int NF = (130 + FOLD - 1) / FOLD;
    localparam int CW = $clog2(NF + 1);
    localparam logic [9:0] LO_LIMIT = 10'(FOLD + 131);
    localparam logic [9:0] FOLD_W   = 10'(FOLD);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FOLD,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [260:0]  r_work;
    logic [8:0]    r_top;
    logic [CW-1:0] r_cnt;

    logic [9:0]      w_top_p1;
    logic [8:0]      w_lo;
    logic [8:0]      w_width;
    logic [FOLD-1:0] w_chunk;
    logic [FOLD+7:0] w_mul;
    logic [260:0]    w_ins;
    logic [260:0]    w_clr_mask;
    logic [260:0]    w_work_nxt;
    logic [8:0]      w_top_nxt;
    logic            w_last_step;

    // Bits above r_top are always zero, so the chunk may be taken as a full
    // FOLD-wide slice even when fewer than FOLD bits remain above bit 130.
    always_comb begin
        w_top_p1 = {1'b0, r_top} + 10'd1;
        if (w_top_p1 >= LO_LIMIT) begin
            w_lo = 9'(w_top_p1 - FOLD_W);
        end else begin
            w_lo = 9'd131;
        end
        w_width    = r_top - w_lo + 9'd1;
        w_chunk    = r_work[w_lo +: FOLD];
        w_mul      = {8'b0, w_chunk} ^ {6'b0, w_chunk, 2'b0}
                   ^ {5'b0, w_chunk, 3'b0} ^ {w_chunk, 8'b0};
        w_ins      = {{(261 - FOLD - 8){1'b0}}, w_mul} << (w_lo - 9'd131);
        w_clr_mask = {{(261 - FOLD){1'b0}}, {FOLD{1'b1}}} << w_lo;
        w_work_nxt = (r_work & ~w_clr_mask) ^ w_ins;
        if (w_lo > 9'd131) begin
            w_top_nxt = w_lo - 9'd1;
        end else begin
            w_top_nxt = w_lo - 9'd124 + w_width;
        end
        w_last_step = (r_cnt == CW'(NF - 1));
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = r_work[130:0];
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_FOLD;
                end
            end
            S_FOLD: begin
                if (w_last_step) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_top   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_work <= in_data;
                        r_top  <= 9'd260;
                        r_cnt  <= '0;
                    end
                end
                S_FOLD: begin
                    r_work <= w_work_nxt;
                    r_top  <= w_top_nxt;
                    r_cnt  <= r_cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
